unidad_condicional: RTL and testbench

- Conditional-execution unit for the ARM datapath. Sits after the ALU (unidad_logico_aritmetica) and consumes its four flags (flagNegativo, flagCero, flagCarry, flagOverflow).
- Holds the architectural NZCV register and evaluates the instruction cond field against it.
- Gates the PC-source, register-write and memory-write strobes, then registers them into the execute→memory pipeline register with stall and flush.

---
 rtl/unidad_condicional_pkg.sv | 36 +++
 rtl/unidad_condicional_evaluador_condicion.sv | 40 ++++
 rtl/unidad_condicional.sv | 137 +++++++++++++
 tb/tb_unidad_condicional.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_condicional_pkg.sv
// Shared types and constants for the conditional-execution unit.
package unidad_condicional_pkg;

    // ARM condition codes, instruction bits [31:28].
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    // Bit positions inside the {N,Z,C,V} vector.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // flag_w encodings.
    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_CV   = 2'b01;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/unidad_condicional_evaluador_condicion.sv
// evaluador_condicion: purely combinational cond-field evaluation against NZCV.
module evaluador_condicion
    import unidad_condicional_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Decode each condition code into its flag predicate; NV never executes.
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_t'(cond_i))
            EQ:      cond_ex_o = z;
            NE:      cond_ex_o = ~z;
            CS:      cond_ex_o = c;
            CC:      cond_ex_o = ~c;
            MI:      cond_ex_o = n;
            PL:      cond_ex_o = ~n;
            VS:      cond_ex_o = v;
            VC:      cond_ex_o = ~v;
            HI:      cond_ex_o = c & ~z;
            LS:      cond_ex_o = ~c | z;
            GE:      cond_ex_o = (n == v);
            LT:      cond_ex_o = (n != v);
            GT:      cond_ex_o = ~z & (n == v);
            LE:      cond_ex_o = z | (n != v);
            AL:      cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidad_condicional.sv
// unidad_condicional: NZCV register, condition evaluation, strobe gating and the
// execute->memory output register. Optional sticky overflow flag under STICKY_Q_EN.
module unidad_condicional
    import unidad_condicional_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs_in,
    input  logic       reg_w_in,
    input  logic       mem_w_in,
    input  logic       no_write_in,
    input  logic       stall,
    input  logic       flush,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic       valid_out,
    output logic       pcs_out,
    output logic       reg_w_out,
    output logic       mem_w_out
`ifdef STICKY_Q_EN
    ,
    input  logic       clr_q,
    output logic       q_flag
`endif
);

    logic [3:0] flags_q, flags_d;
    logic       valid_q, valid_d;
    logic       pcs_q, pcs_d;
    logic       reg_w_q, reg_w_d;
    logic       mem_w_q, mem_w_d;
    logic       ok;
    logic       gp, gr, gm;

    // Condition is always judged against the registered (pre-update) flags.
    evaluador_condicion u_evaluador (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    assign ok = valid_in & cond_ex & ~stall & ~flush;

    assign gp = valid_in & pcs_in & cond_ex;
    assign gr = valid_in & reg_w_in & cond_ex & ~no_write_in;
    assign gm = valid_in & mem_w_in & cond_ex;

    // Next NZCV: committed instructions update the selected flag pairs.
    always_comb begin
        flags_d = flags_q;
        if (ok && ((flag_w & FW_NZ) != FW_NONE)) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (ok && ((flag_w & FW_CV) != FW_NONE)) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    // Output register next state: flush beats stall, stall holds.
    always_comb begin
        valid_d = valid_q;
        pcs_d   = pcs_q;
        reg_w_d = reg_w_q;
        mem_w_d = mem_w_q;
        if (flush) begin
            valid_d = 1'b0;
            pcs_d   = 1'b0;
            reg_w_d = 1'b0;
            mem_w_d = 1'b0;
        end else if (!stall) begin
            valid_d = valid_in;
            pcs_d   = gp;
            reg_w_d = gr;
            mem_w_d = gm;
        end
    end

    // Flag and pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= RESET_FLAGS;
            valid_q <= 1'b0;
            pcs_q   <= 1'b0;
            reg_w_q <= 1'b0;
            mem_w_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
            pcs_q   <= pcs_d;
            reg_w_q <= reg_w_d;
            mem_w_q <= mem_w_d;
        end
    end

    assign flags     = flags_q;
    assign valid_out = valid_q;
    assign pcs_out   = pcs_q;
    assign reg_w_out = reg_w_q;
    assign mem_w_out = mem_w_q;

`ifdef STICKY_Q_EN
    logic q_q, q_d;
    logic q_set;

    assign q_set = ok & flag_w[0] & alu_flags[FLAG_V];

    // Sticky overflow: set wins over a coincident clear.
    always_comb begin
        q_d = q_q;
        if (q_set) begin
            q_d = 1'b1;
        end else if (clr_q) begin
            q_d = 1'b0;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_flag = q_q;
`endif

endmodule

// File: tb/tb_unidad_condicional.sv
// Self-checking bench for unidad_condicional: condition table, directed
// sequences and randomized traffic against a behavioural model.
module tb_unidad_condicional;
    import unidad_condicional_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] cond = 4'b1110;
    logic [3:0] alu_flags = 4'b0000;
    logic [1:0] flag_w = 2'b00;
    logic       pcs_in = 1'b0, reg_w_in = 1'b0, mem_w_in = 1'b0, no_write_in = 1'b0;
    logic       stall = 1'b0, flush = 1'b0;
    logic       cond_ex;
    logic [3:0] flags;
    logic       valid_out, pcs_out, reg_w_out, mem_w_out;
    logic       clr_q = 1'b0;
`ifdef STICKY_Q_EN
    logic       q_flag;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [3:0] m_flags;
    logic       m_valid, m_pcs, m_regw, m_memw, m_q;

    unidad_condicional dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_w      (flag_w),
        .pcs_in      (pcs_in),
        .reg_w_in    (reg_w_in),
        .mem_w_in    (mem_w_in),
        .no_write_in (no_write_in),
        .stall       (stall),
        .flush       (flush),
        .cond_ex     (cond_ex),
        .flags       (flags),
        .valid_out   (valid_out),
        .pcs_out     (pcs_out),
        .reg_w_out   (reg_w_out),
        .mem_w_out   (mem_w_out)
`ifdef STICKY_Q_EN
        ,
        .clr_q       (clr_q),
        .q_flag      (q_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Pairs of codes share a predicate; the odd code is its negation. 111x: AL / never.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c == 4'b1110);
        endcase
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_valid = 1'b0; m_pcs = 1'b0; m_regw = 1'b0; m_memw = 1'b0; m_q = 1'b0;
    endtask

    task automatic model_clock();
        logic ce, ok;
        ce = cond_model(cond, m_flags);
        ok = valid_in && ce && !stall && !flush;
        if (ok && valid_in && flag_w[0] && alu_flags[0]) m_q = 1'b1;
        else if (clr_q) m_q = 1'b0;
        if (ok && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
        if (ok && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
        if (flush) begin
            m_valid = 0; m_pcs = 0; m_regw = 0; m_memw = 0;
        end else if (!stall) begin
            m_valid = valid_in;
            m_pcs   = valid_in && pcs_in && ce;
            m_regw  = valid_in && reg_w_in && ce && !no_write_in;
            m_memw  = valid_in && mem_w_in && ce;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".flags"}, flags, m_flags);
        check({tag, ".valid_out"}, 4'(valid_out), 4'(m_valid));
        check({tag, ".pcs_out"}, 4'(pcs_out), 4'(m_pcs));
        check({tag, ".reg_w_out"}, 4'(reg_w_out), 4'(m_regw));
        check({tag, ".mem_w_out"}, 4'(mem_w_out), 4'(m_memw));
`ifdef STICKY_Q_EN
        check({tag, ".q_flag"}, 4'(q_flag), 4'(m_q));
`endif
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".cond_ex"}, 4'(cond_ex), 4'(cond_model(cond, m_flags)));
        @(posedge clk);
        model_clock();
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [3:0] c, input logic [3:0] a,
                          input logic [1:0] fw, input logic p, input logic r,
                          input logic m, input logic nw);
        valid_in = v; cond = c; alu_flags = a; flag_w = fw;
        pcs_in = p; reg_w_in = r; mem_w_in = m; no_write_in = nw;
    endtask

    typedef struct packed {
        logic [3:0] nzcv;
        logic [3:0] c;
        logic       exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 1'b0};  // EQ, Z=0
        vecs[1]  = '{4'b0100, 4'b0000, 1'b1};  // EQ, Z=1
        vecs[2]  = '{4'b0100, 4'b0001, 1'b0};  // NE
        vecs[3]  = '{4'b0010, 4'b0010, 1'b1};  // CS
        vecs[4]  = '{4'b0010, 4'b1000, 1'b1};  // HI
        vecs[5]  = '{4'b0110, 4'b1000, 1'b0};  // HI with Z
        vecs[6]  = '{4'b0110, 4'b1001, 1'b1};  // LS
        vecs[7]  = '{4'b1000, 4'b1010, 1'b0};  // GE, N!=V
        vecs[8]  = '{4'b1001, 4'b1010, 1'b1};  // GE, N==V
        vecs[9]  = '{4'b1001, 4'b1100, 1'b1};  // GT
        vecs[10] = '{4'b1101, 4'b1101, 1'b1};  // LE via Z
        vecs[11] = '{4'b0001, 4'b1011, 1'b1};  // LT
        vecs[12] = '{4'b0000, 4'b1111, 1'b0};  // never
        vecs[13] = '{4'b0000, 4'b1110, 1'b1};  // AL
        vecs[14] = '{4'b1000, 4'b0100, 1'b1};  // MI
        vecs[15] = '{4'b0001, 4'b0111, 1'b0};  // VC

        model_reset();
        // 1. Reset behaviour.
        @(negedge clk);
        @(negedge clk);
        check("reset.flags", flags, 4'b0000);
        check("reset.valid_out", 4'(valid_out), 4'd0);
        check("reset.strobes", {1'b0, pcs_out, reg_w_out, mem_w_out}, 4'd0);
        rst = 1'b0;
        set_in(0, EQ, 0, FW_NONE, 0, 0, 0, 0); #1;
        check("reset.EQ", 4'(cond_ex), 4'd0);
        cond = AL; #1;
        check("reset.AL", 4'(cond_ex), 4'd1);
        cond = NV; #1;
        check("reset.NV", 4'(cond_ex), 4'd0);
        @(negedge clk);

        // Condition table: load NZCV via an AL full update, then probe cond.
        for (int i = 0; i < 16; i++) begin
            set_in(1, AL, vecs[i].nzcv, FW_ALL, 0, 0, 0, 0);
            cycle("tbl_load");
            set_in(0, vecs[i].c, 4'b0000, FW_NONE, 0, 0, 0, 0);
            #1;
            check($sformatf("tbl[%0d].cond_ex", i), 4'(cond_ex), 4'(vecs[i].exp));
        end
        @(negedge clk);

        // 2. ADD 1010+0110 sets Z and C, then EQ/NE gated writes.
        set_in(1, AL, 4'b0000, FW_ALL, 0, 0, 0, 0);
        cycle("clr");
        set_in(1, AL, 4'b0110, FW_ALL, 0, 0, 0, 0);
        cycle("add");
        check("add.flags", flags, 4'b0110);
        set_in(1, EQ, 4'b0000, FW_NONE, 0, 1, 0, 0);
        cycle("eq_w");
        check("eq_w.reg_w_out", 4'(reg_w_out), 4'd1);
        set_in(1, NE, 4'b0000, FW_NONE, 1, 1, 1, 0);
        cycle("ne_w");
        check("ne_w.reg_w_out", 4'(reg_w_out), 4'd0);
        check("ne_w.valid_out", 4'(valid_out), 4'd1);

        // 3. Partial NZ update.
        set_in(1, AL, 4'b1001, FW_NZ, 0, 0, 0, 0);
        cycle("part");
        check("part.flags", flags, 4'b1010);
        set_in(0, GE, 0, FW_NONE, 0, 0, 0, 0); #1;
        check("part.GE", 4'(cond_ex), 4'd0);
        cond = LT; #1;
        check("part.LT", 4'(cond_ex), 4'd1);
        cond = LE; #1;
        check("part.LE", 4'(cond_ex), 4'd1);
        @(negedge clk);

        // 4. Compare-class: flags update, register write suppressed.
        set_in(1, AL, 4'b0100, FW_ALL, 0, 1, 0, 1);
        cycle("cmp");
        check("cmp.reg_w_out", 4'(reg_w_out), 4'd0);
        check("cmp.flags", flags, 4'b0100);

        // 5. Stall freezes outputs and flags.
        set_in(1, AL, 4'b0100, FW_NONE, 1, 1, 1, 0);
        cycle("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(logic'(i[0]), AL, 4'(4'b1011 ^ i), FW_ALL, 0, 0, 0, 0);
            cycle("stall");
            check("stall.frozen", {pcs_out, reg_w_out, mem_w_out, valid_out}, 4'b1111);
            check("stall.flags", flags, 4'b0100);
        end
        flush = 1'b1;
        set_in(1, AL, 4'b1111, FW_ALL, 1, 1, 1, 0);
        cycle("stall_flush");
        check("stall_flush.valid_out", 4'(valid_out), 4'd0);
        check("stall_flush.flags", flags, 4'b0100);
        stall = 1'b0; flush = 1'b0;
        set_in(1, AL, 4'b0011, FW_ALL, 1, 1, 1, 0);
        cycle("pre_rst");
        // Async reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst.valid_out", 4'(valid_out), 4'd0);
        check("arst.strobes", {1'b0, pcs_out, reg_w_out, mem_w_out}, 4'd0);
        check("arst.flags", flags, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

`ifdef STICKY_Q_EN
        // 6. Sticky overflow.
        set_in(1, AL, 4'b0001, FW_CV, 0, 0, 0, 0);
        cycle("q_set");
        check("q_set.q_flag", 4'(q_flag), 4'd1);
        set_in(1, AL, 4'b0000, FW_CV, 0, 0, 0, 0);
        cycle("q_keep");
        check("q_keep.q_flag", 4'(q_flag), 4'd1);
        set_in(0, AL, 4'b0000, FW_NONE, 0, 0, 0, 0);
        clr_q = 1'b1;
        cycle("q_clr");
        check("q_clr.q_flag", 4'(q_flag), 4'd0);
        set_in(1, AL, 4'b0001, FW_CV, 0, 0, 0, 0);
        cycle("q_both");
        check("q_both.q_flag", 4'(q_flag), 4'd1);
        clr_q = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 9) < 8), 4'($urandom), 4'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
`ifdef STICKY_Q_EN
            clr_q = ($urandom_range(0, 9) == 0);
`endif
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
